pbit_gibbs_scheduler: RTL

- Time-multiplexes one external pbit instance across N_SPINS logical spins. Runs sequential Gibbs sweeps.
- For each spin i, it computes the local field z_i = h_i + sum over j!=i of J_ij*m_j, where m_j = +1 if spins[j]=1 and -1 if spins[j]=0.
- It drives z_i into the pbit, holds it for a settle window, then captures pbit_val into spins[i].
- Weights and biases are read from an external synchronous memory with 1-cycle read latency.

---
 rtl/pbit_pkg.sv | 28 ++
 rtl/pbit_gibbs_scheduler_field_acc.sv | 41 ++++
 rtl/pbit_gibbs_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pbit_pkg.sv
// Shared fixed-point sizes, saturation limits, scheduler FSM encoding and the
// saturating narrowing function for the pbit Gibbs scheduler.
package pbit_pkg;

  localparam int INT_SIZE   = 8;
  localparam int FLOAT_SIZE = 24;
  localparam int Z_W        = INT_SIZE + FLOAT_SIZE;

  localparam longint Z_MAX_L = (longint'(1) <<< (Z_W - 1)) - 1;
  localparam longint Z_MIN_L = -(longint'(1) <<< (Z_W - 1));
  localparam logic [Z_W-1:0] Z_MAX = Z_W'(Z_MAX_L);
  localparam logic [Z_W-1:0] Z_MIN = Z_W'(Z_MIN_L);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_SETTLE,
    ST_DONE
  } sched_state_e;

  function automatic logic [Z_W-1:0] sat_z(input longint v);
    if (v > Z_MAX_L) return Z_MAX;
    else if (v < Z_MIN_L) return Z_MIN;
    else return Z_W'(v);
  endfunction

endpackage

// File: rtl/pbit_gibbs_scheduler_field_acc.sv
// Local-field accumulator: adds or subtracts each coupling word by the sign of
// the neighbour spin, skips the diagonal, adds the bias, saturates to Z_W bits.
module pbit_field_acc
  import pbit_pkg::*;
#(
  parameter int ACC_W = Z_W + 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  add_en,
  input  logic                  is_bias,
  input  logic                  diag,
  input  logic                  spin_bit,
  input  logic signed [Z_W-1:0] w_data,
  output logic [Z_W-1:0]        z_sat_next
);

  logic signed [ACC_W-1:0] acc_q, acc_d, w_ext;

  assign w_ext = ACC_W'(w_data);

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      if (is_bias || (spin_bit && !diag)) acc_d = acc_q + w_ext;
      else if (!diag)                     acc_d = acc_q - w_ext;
    end
  end

  // The next value is exported so z_out can load in the same cycle the bias lands.
  assign z_sat_next = sat_z(longint'(acc_d));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/pbit_gibbs_scheduler.sv
// Sequential Gibbs sweep scheduler sharing one external pbit across N_SPINS spins.
// Optional clamping of spins is enabled with `define PBIT_SCHED_CLAMP_EN.
module pbit_gibbs_scheduler
  import pbit_pkg::*;
#(
  parameter int                N_SPINS    = 4,
  parameter int                SETTLE_CYC = 4,
  parameter int                SWEEP_W    = 16,
  parameter logic [N_SPINS-1:0] SPIN_INIT = '0,
  localparam int               AW         = $clog2(N_SPINS * (N_SPINS + 1))
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [SWEEP_W-1:0]    num_sweeps,
  output logic                  busy,
  output logic                  done,
  output logic [SWEEP_W-1:0]    sweep_cnt,
  output logic                  w_rd_en,
  output logic [AW-1:0]         w_addr,
  input  logic signed [Z_W-1:0] w_data,
  output logic [Z_W-1:0]        z_out,
  input  logic                  pbit_val,
  output logic [N_SPINS-1:0]    spins,
`ifdef PBIT_SCHED_CLAMP_EN
  input  logic [N_SPINS-1:0]    clamp_mask,
  input  logic [N_SPINS-1:0]    clamp_val,
`endif
  output sched_state_e          state_dbg
);

  localparam int IW    = $clog2(N_SPINS);
  localparam int KW    = $clog2(N_SPINS + 1);
  localparam int SW    = $clog2(SETTLE_CYC + 1);
  localparam int ACC_W = Z_W + $clog2(N_SPINS + 1) + 1;

  sched_state_e       state_q, state_d;
  logic [IW-1:0]      i_q, i_d;
  logic [KW-1:0]      k_q, k_d, j_idx;
  logic [SW-1:0]      settle_q, settle_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d, nsw_q, nsw_d;
  logic [N_SPINS-1:0] spins_q, spins_d;
  logic [Z_W-1:0]     z_out_q, z_out_d, z_sat_next;
  logic [N_SPINS-1:0] start_mask, start_val, skip_mask, search_mask;
  logic [IW-1:0]      first_idx, next_idx;
  logic               first_ok, next_ok, last_settle, sweep_last;

`ifdef PBIT_SCHED_CLAMP_EN
  logic [N_SPINS-1:0] skip_mask_q, skip_mask_d;
  assign start_mask  = clamp_mask;
  assign start_val   = clamp_val;
  assign skip_mask_d = (state_q == ST_IDLE && start) ? clamp_mask : skip_mask_q;
  assign skip_mask   = skip_mask_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) skip_mask_q <= '0;
    else     skip_mask_q <= skip_mask_d;
  end
`else
  assign start_mask = '0;
  assign start_val  = '0;
  assign skip_mask  = '0;
`endif

  // In IDLE the mask being latched this cycle decides the first spin to visit.
  assign search_mask = (state_q == ST_IDLE) ? start_mask : skip_mask;

  always_comb begin
    first_ok  = 1'b0;
    first_idx = '0;
    next_ok   = 1'b0;
    next_idx  = '0;
    for (int j = N_SPINS - 1; j >= 0; j--) begin
      if (!search_mask[j]) begin
        first_ok  = 1'b1;
        first_idx = IW'(j);
        if (j > int'(i_q)) begin
          next_ok  = 1'b1;
          next_idx = IW'(j);
        end
      end
    end
  end

  assign last_settle = (state_q == ST_SETTLE) && (settle_q == SW'(SETTLE_CYC - 1));
  assign sweep_last  = ((sweep_q + SWEEP_W'(1)) == nsw_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = (num_sweeps == '0 || !first_ok) ? ST_DONE : ST_FETCH;
      ST_FETCH:  if (k_q == KW'(N_SPINS)) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_SETTLE;
      ST_SETTLE: if (last_settle) state_d = (next_ok || !sweep_last) ? ST_FETCH : ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == ST_FETCH) || (state_q == ST_DRAIN) || (state_q == ST_SETTLE);
    done    = (state_q == ST_DONE);
    w_rd_en = (state_q == ST_FETCH);
    w_addr  = w_rd_en ? AW'(int'(i_q) * (N_SPINS + 1) + int'(k_q)) : '0;
  end

  always_comb begin
    i_d      = i_q;
    k_d      = k_q;
    settle_d = settle_q;
    sweep_d  = sweep_q;
    nsw_d    = nsw_q;
    spins_d  = spins_q;
    z_out_d  = z_out_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        spins_d  = (spins_q & ~start_mask) | (start_val & start_mask);
        i_d      = '0;
        k_d      = '0;
        settle_d = '0;
        if (num_sweeps != '0) begin
          nsw_d   = num_sweeps;
          sweep_d = first_ok ? '0 : num_sweeps;
          i_d     = first_ok ? first_idx : '0;
        end
      end
      ST_FETCH:  k_d = (k_q == KW'(N_SPINS)) ? '0 : k_q + KW'(1);
      ST_DRAIN: begin
        z_out_d  = z_sat_next;
        settle_d = '0;
      end
      ST_SETTLE: begin
        settle_d = settle_q + SW'(1);
        if (last_settle) begin
          spins_d[i_q] = pbit_val;
          settle_d     = '0;
          k_d          = '0;
          if (next_ok) begin
            i_d = next_idx;
          end else begin
            sweep_d = sweep_q + SWEEP_W'(1);
            i_d     = sweep_last ? '0 : first_idx;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_q      <= '0;
      k_q      <= '0;
      settle_q <= '0;
      sweep_q  <= '0;
      nsw_q    <= '0;
      spins_q  <= SPIN_INIT;
      z_out_q  <= '0;
    end else begin
      i_q      <= i_d;
      k_q      <= k_d;
      settle_q <= settle_d;
      sweep_q  <= sweep_d;
      nsw_q    <= nsw_d;
      spins_q  <= spins_d;
      z_out_q  <= z_out_d;
    end
  end

  // Word k-1 arrives while word k is being addressed; j_idx names the arriving word.
  assign j_idx = k_q - KW'(1);

  pbit_field_acc #(.ACC_W(ACC_W)) u_acc (
    .CLK        (CLK),
    .RST        (RST),
    .clr        (state_q == ST_FETCH && k_q == '0),
    .add_en     ((state_q == ST_FETCH && k_q != '0) || state_q == ST_DRAIN),
    .is_bias    (state_q == ST_DRAIN),
    .diag       (int'(j_idx) == int'(i_q)),
    .spin_bit   ((int'(j_idx) < N_SPINS) ? spins_q[IW'(j_idx)] : 1'b0),
    .w_data     (w_data),
    .z_sat_next (z_sat_next)
  );

  assign sweep_cnt = sweep_q;
  assign z_out     = z_out_q;
  assign spins     = spins_q;
  assign state_dbg = state_q;

endmodule
